// File: rtl/updn_mod_counter.sv
// updn_mod_counter: modulo-MAX_COUNT up/down counter with saturating
// parallel load, registered terminal-count flags, a wrap pulse and a
// snapshot (capture) register. Synchronous active-low reset.
module updn_mod_counter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_COUNT = 10
) (
    input  logic             clk,
    input  logic             rst_s,
    input  logic             enb,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             capture,
    output logic [WIDTH-1:0] q,
    output logic             cnt_max,
    output logic             cnt_zero,
    output logic             wrap,
    output logic [WIDTH-1:0] cap_q,
    output logic             cap_valid
);

    // Terminal count value, MAX_COUNT-1, always representable in WIDTH bits.
    localparam logic [WIDTH-1:0] TOP  = WIDTH'(MAX_COUNT - 1);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    // Reject parameter sets where the modulus does not fit the counter width.
    if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
        $error("updn_mod_counter: WIDTH must be in 1..31");
    end
    if (MAX_COUNT < 2 || 64'(MAX_COUNT) > (64'(1) << WIDTH)) begin : g_bad_mod
        $error("updn_mod_counter: MAX_COUNT must be in 2..2**WIDTH");
    end

    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;
    logic [WIDTH-1:0] load_sat;
    logic             at_top;
    logic             at_zero;

    // Saturate out-of-range load values to the terminal count.
    always_comb begin
        load_sat = TOP;
        if (32'(load_val) < MAX_COUNT) begin
            load_sat = load_val;
        end
    end

    // Position of the current count relative to both wrap points.
    always_comb begin
        at_top  = (q == TOP);
        at_zero = (q == ZERO);
    end

    // Next count and wrap request: load beats counting, counting beats hold.
    always_comb begin
        q_nxt    = q;
        wrap_nxt = 1'b0;
        if (load) begin
            q_nxt = load_sat;
        end else if (enb) begin
            if (up_dn) begin
                if (at_top) begin
                    q_nxt    = ZERO;
                    wrap_nxt = 1'b1;
                end else begin
                    q_nxt = q + ONE;
                end
            end else begin
                if (at_zero) begin
                    q_nxt    = TOP;
                    wrap_nxt = 1'b1;
                end else begin
                    q_nxt = q - ONE;
                end
            end
        end
    end

    // Count register with flags decoded from the next value so they track q exactly.
    always_ff @(posedge clk) begin
        if (!rst_s) begin
            q        <= ZERO;
            cnt_max  <= 1'b0;
            cnt_zero <= 1'b1;
            wrap     <= 1'b0;
        end else begin
            q        <= q_nxt;
            cnt_max  <= (q_nxt == TOP);
            cnt_zero <= (q_nxt == ZERO);
            wrap     <= wrap_nxt;
        end
    end

    // Snapshot of the pre-edge count, with a one-cycle valid pulse.
    always_ff @(posedge clk) begin
        if (!rst_s) begin
            cap_q     <= ZERO;
            cap_valid <= 1'b0;
        end else begin
            cap_valid <= capture;
            if (capture) begin
                cap_q <= q;
            end
        end
    end

endmodule

// File: tb/tb_updn_mod_counter.sv
// Testbench for updn_mod_counter: directed scenarios plus randomized
// stimulus compared every cycle against an arithmetic reference model.
module tb_updn_mod_counter;

    localparam int unsigned W = 4;
    localparam int unsigned M = 10;

    logic         clk = 1'b0;
    logic         rst_s, enb, up_dn, load, capture;
    logic [W-1:0] load_val;
    logic [W-1:0] q, cap_q;
    logic         cnt_max, cnt_zero, wrap, cap_valid;

    int checks   = 0;
    int failures = 0;

    // Reference state
    int m_q, m_wrap, m_capq, m_capv;

    always #5 clk = ~clk;

    updn_mod_counter #(.WIDTH(W), .MAX_COUNT(M)) dut (
        .clk       (clk),
        .rst_s     (rst_s),
        .enb       (enb),
        .up_dn     (up_dn),
        .load      (load),
        .load_val  (load_val),
        .capture   (capture),
        .q         (q),
        .cnt_max   (cnt_max),
        .cnt_zero  (cnt_zero),
        .wrap      (wrap),
        .cap_q     (cap_q),
        .cap_valid (cap_valid)
    );

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model of one rising edge, from the counting rules.
    task automatic model_step();
        if (!rst_s) begin
            m_q = 0; m_wrap = 0; m_capq = 0; m_capv = 0;
        end else begin
            m_capv = capture ? 1 : 0;
            if (capture) m_capq = m_q;
            if (load) begin
                m_q    = (int'(load_val) < int'(M)) ? int'(load_val) : int'(M) - 1;
                m_wrap = 0;
            end else if (enb) begin
                if (up_dn) begin
                    m_wrap = (m_q == int'(M) - 1) ? 1 : 0;
                    m_q    = (m_q + 1) % int'(M);
                end else begin
                    m_wrap = (m_q == 0) ? 1 : 0;
                    m_q    = (m_q + int'(M) - 1) % int'(M);
                end
            end else begin
                m_wrap = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"},         32'(q),         32'(m_q));
        check({tag, ".cnt_max"},   32'(cnt_max),   32'(m_q == int'(M) - 1));
        check({tag, ".cnt_zero"},  32'(cnt_zero),  32'(m_q == 0));
        check({tag, ".wrap"},      32'(wrap),      32'(m_wrap));
        check({tag, ".cap_q"},     32'(cap_q),     32'(m_capq));
        check({tag, ".cap_valid"}, 32'(cap_valid), 32'(m_capv));
    endtask

    // Drive one cycle of inputs, clock it, and compare everything afterwards.
    task automatic cycle(input string tag, input logic r, input logic e, input logic u,
                         input logic l, input int lv, input logic c);
        rst_s    = r;
        enb      = e;
        up_dn    = u;
        load     = l;
        load_val = W'(lv);
        capture  = c;
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        cycle("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic do_load(input int v);
        cycle("load", 1'b1, 1'b0, 1'b0, 1'b1, v, 1'b0);
    endtask

    initial begin
        m_q = 0; m_wrap = 0; m_capq = 0; m_capv = 0;

        // Reset state, with load/enb/capture asserted to prove they are overridden
        cycle("rst_ovr", 1'b0, 1'b1, 1'b1, 1'b1, 5, 1'b1);
        do_reset();
        check("rst.cnt_zero", 32'(cnt_zero), 32'd1);
        check("rst.q", 32'(q), 32'd0);

        // Up count through a full modulo cycle
        for (int i = 1; i <= 10; i++) begin
            cycle("up_wrap", 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
            check("up_wrap.q_seq", 32'(q), 32'(i % 10));
        end
        check("up_wrap.wrap_at_0", 32'(wrap), 32'd1);

        // Down wrap out of zero
        do_reset();
        cycle("dn_wrap", 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        check("dn_wrap.q", 32'(q), 32'd9);
        check("dn_wrap.wrap", 32'(wrap), 32'd1);
        check("dn_wrap.cnt_max", 32'(cnt_max), 32'd1);
        check("dn_wrap.cnt_zero", 32'(cnt_zero), 32'd0);

        // Load saturation and load-over-enable priority
        cycle("ld_sat", 1'b1, 1'b1, 1'b1, 1'b1, 13, 1'b0);
        check("ld_sat.q", 32'(q), 32'd9);
        check("ld_sat.wrap", 32'(wrap), 32'd0);
        cycle("ld_zero", 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        check("ld_zero.q", 32'(q), 32'd0);
        check("ld_zero.wrap", 32'(wrap), 32'd0);

        // Capture colliding with a wrap, then with a load
        do_load(9);
        cycle("cap_wrap", 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        check("cap_wrap.q", 32'(q), 32'd0);
        check("cap_wrap.cap_q", 32'(cap_q), 32'd9);
        check("cap_wrap.cap_valid", 32'(cap_valid), 32'd1);
        check("cap_wrap.wrap", 32'(wrap), 32'd1);
        do_load(6);
        check("cap_ld.cap_valid_drop", 32'(cap_valid), 32'd0);
        cycle("cap_ld", 1'b1, 1'b1, 1'b1, 1'b1, 4, 1'b1);
        check("cap_ld.q", 32'(q), 32'd4);
        check("cap_ld.cap_q", 32'(cap_q), 32'd6);

        // Reset colliding with a capture mid-count
        do_load(7);
        cycle("rst_cap", 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        check("rst_cap.q", 32'(q), 32'd0);
        check("rst_cap.cap_q", 32'(cap_q), 32'd0);
        check("rst_cap.cap_valid", 32'(cap_valid), 32'd0);
        check("rst_cap.cnt_zero", 32'(cnt_zero), 32'd1);

        // Hold, then direction flipping every edge
        do_load(5);
        for (int i = 0; i < 3; i++) begin
            cycle("hold", 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
            check("hold.q", 32'(q), 32'd5);
        end
        for (int i = 0; i < 4; i++) begin
            cycle("flip", 1'b1, 1'b1, ((i % 2) == 0), 1'b0, 0, 1'b0);
            check("flip.q", 32'(q), ((i % 2) == 0) ? 32'd6 : 32'd5);
        end

        // Reset falling between edges must not disturb outputs
        do_load(3);
        rst_s = 1'b0;
        #2;
        check("async_rst.q", 32'(q), 32'd3);
        check("async_rst.cnt_zero", 32'(cnt_zero), 32'd0);
        cycle("async_rst_edge", 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle("rand",
                  ($urandom_range(49) != 0),
                  ($urandom_range(3) != 0),
                  1'($urandom_range(1)),
                  ($urandom_range(7) == 0),
                  int'($urandom_range(2**W - 1)),
                  ($urandom_range(3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
